// File: rtl/endian_pkg.sv
// -----------------------------------------------------------------------------
// endian_pkg
//
// Shared types and helpers for the streaming byte-order converter.
//
//   swap_mode_e : the four lane permutations selectable per packet.
//   pkt_state_e : packet tracking state (between packets / inside a packet).
//   src_lane()  : for a given mode, output lane k and lane count n, returns
//                 the input lane that feeds output lane k. It is evaluated
//                 at elaboration time only, so every mux in lane_permute
//                 has constant select inputs per mode.
// -----------------------------------------------------------------------------
package endian_pkg;

  typedef enum logic [1:0] {
    SWAP_PASS   = 2'd0,  // out lane k <- in lane k
    SWAP_FULL   = 2'd1,  // full byte reversal
    SWAP_HALF16 = 2'd2,  // swap bytes inside each 16-bit lane pair
    SWAP_WORD16 = 2'd3   // keep lane pairs intact, reverse pair order
  } swap_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } pkt_state_e;

  // Source-lane mapping. n must be even; odd n would make the pair-based
  // modes reach outside the beat.
  function automatic int src_lane(swap_mode_e mode, int k, int n);
    int src;
    src = k;
    case (mode)
      SWAP_PASS:   src = k;
      SWAP_FULL:   src = n - 1 - k;
      SWAP_HALF16: src = k ^ 1;
      SWAP_WORD16: src = (n - 2 - (k & ~1)) + (k & 1);
      default:     src = k;
    endcase
    return src;
  endfunction

endpackage : endian_pkg

// File: rtl/lane_permute.sv
// -----------------------------------------------------------------------------
// lane_permute
//
// Purely combinational lane permutation. Each output lane selects one of up
// to four input lanes according to mode_i; the keep bit of a lane travels
// with its data byte so the permuted mask still describes the permuted data.
//
// Parameters
//   BYTE_SIZE   : bits per lane
//   INPUT_BYTES : lanes per beat (even, >= 2)
//
// Ports
//   data_i : input beat, lane 0 in bits [BYTE_SIZE-1:0]
//   keep_i : input lane-valid mask
//   mode_i : permutation to apply
//   data_o : permuted beat
//   keep_o : permuted lane-valid mask
// -----------------------------------------------------------------------------
module lane_permute
  import endian_pkg::*;
#(
  parameter int BYTE_SIZE   = 8,
  parameter int INPUT_BYTES = 4
) (
  input  logic [INPUT_BYTES*BYTE_SIZE-1:0] data_i,
  input  logic [INPUT_BYTES-1:0]           keep_i,
  input  swap_mode_e                       mode_i,
  output logic [INPUT_BYTES*BYTE_SIZE-1:0] data_o,
  output logic [INPUT_BYTES-1:0]           keep_o
);

  genvar gi;
  generate
    for (gi = 0; gi < INPUT_BYTES; gi++) begin : g_lane
      // Source lane for this output lane under each mode, resolved at
      // elaboration so the per-lane logic is a plain 4:1 mux.
      localparam int SRC_PASS   = src_lane(SWAP_PASS,   gi, INPUT_BYTES);
      localparam int SRC_FULL   = src_lane(SWAP_FULL,   gi, INPUT_BYTES);
      localparam int SRC_HALF16 = src_lane(SWAP_HALF16, gi, INPUT_BYTES);
      localparam int SRC_WORD16 = src_lane(SWAP_WORD16, gi, INPUT_BYTES);

      logic [BYTE_SIZE-1:0] lane_data;
      logic                 lane_keep;

      always_comb begin
        lane_data = data_i[SRC_PASS*BYTE_SIZE +: BYTE_SIZE];
        lane_keep = keep_i[SRC_PASS];
        case (mode_i)
          SWAP_PASS: begin
            lane_data = data_i[SRC_PASS*BYTE_SIZE +: BYTE_SIZE];
            lane_keep = keep_i[SRC_PASS];
          end
          SWAP_FULL: begin
            lane_data = data_i[SRC_FULL*BYTE_SIZE +: BYTE_SIZE];
            lane_keep = keep_i[SRC_FULL];
          end
          SWAP_HALF16: begin
            lane_data = data_i[SRC_HALF16*BYTE_SIZE +: BYTE_SIZE];
            lane_keep = keep_i[SRC_HALF16];
          end
          SWAP_WORD16: begin
            lane_data = data_i[SRC_WORD16*BYTE_SIZE +: BYTE_SIZE];
            lane_keep = keep_i[SRC_WORD16];
          end
          default: begin
            lane_data = data_i[SRC_PASS*BYTE_SIZE +: BYTE_SIZE];
            lane_keep = keep_i[SRC_PASS];
          end
        endcase
      end

      assign data_o[gi*BYTE_SIZE +: BYTE_SIZE] = lane_data;
      assign keep_o[gi]                        = lane_keep;
    end
  endgenerate

endmodule : lane_permute

// File: rtl/endian_swap_stream.sv
// -----------------------------------------------------------------------------
// endian_swap_stream
//
// Streaming byte-order converter with valid/ready handshakes on both sides.
// The swap mode is sampled on the first beat of each packet and held for the
// rest of it; beats are permuted before being registered, so both the output
// register and the skid register always hold already-swapped beats.
//
// Parameters
//   BYTE_SIZE   : bits per lane
//   INPUT_BYTES : lanes per beat (even, >= 2)
//   CNT_W       : width of the packet / beat counters
//
// Ports
//   clk, rst         : clock, synchronous active-high reset
//   mode_i           : swap mode, sampled on the first beat of a packet
//   s_data_i/s_keep_i/s_last_i/s_valid_i/s_ready_o : input stream
//   m_data_o/m_keep_o/m_last_o/m_valid_o/m_ready_i : output stream
//   pkt_cnt_o        : completed output packets (wraps)
//   beat_cnt_o       : beats of the current output packet transferred so far
//   mode_ignored_o   : sticky, mode_i changed mid-packet on an accepted beat
// -----------------------------------------------------------------------------
module endian_swap_stream
  import endian_pkg::*;
#(
  parameter int BYTE_SIZE   = 8,
  parameter int INPUT_BYTES = 4,
  parameter int CNT_W       = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [1:0]                       mode_i,
  input  logic [INPUT_BYTES*BYTE_SIZE-1:0] s_data_i,
  input  logic [INPUT_BYTES-1:0]           s_keep_i,
  input  logic                             s_last_i,
  input  logic                             s_valid_i,
  output logic                             s_ready_o,
  output logic [INPUT_BYTES*BYTE_SIZE-1:0] m_data_o,
  output logic [INPUT_BYTES-1:0]           m_keep_o,
  output logic                             m_last_o,
  output logic                             m_valid_o,
  input  logic                             m_ready_i,
  output logic [CNT_W-1:0]                 pkt_cnt_o,
  output logic [CNT_W-1:0]                 beat_cnt_o,
  output logic                             mode_ignored_o
);

  localparam int DATA_W = INPUT_BYTES * BYTE_SIZE;

  // ---------------------------------------------------------------------------
  // Pipeline storage: one output register and one skid register.
  // ---------------------------------------------------------------------------
  logic              out_valid_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [INPUT_BYTES-1:0] out_keep_reg;
  logic              out_last_reg;

  logic              skid_valid_reg;
  logic [DATA_W-1:0] skid_data_reg;
  logic [INPUT_BYTES-1:0] skid_keep_reg;
  logic              skid_last_reg;

  // ---------------------------------------------------------------------------
  // Packet tracking state
  // ---------------------------------------------------------------------------
  pkt_state_e state_reg, state_next;
  swap_mode_e mode_reg, mode_next;
  logic       mode_ignored_reg, mode_ignored_next;

  logic [CNT_W-1:0] pkt_cnt_reg;
  logic [CNT_W-1:0] beat_cnt_reg;

  swap_mode_e             mode_in;
  swap_mode_e             eff_mode;
  logic                   accept;
  logic                   out_xfer;
  logic                   out_free;
  logic [DATA_W-1:0]      sw_data;
  logic [INPUT_BYTES-1:0] sw_keep;

  assign mode_in = swap_mode_e'(mode_i);

  // Ready depends only on a register, so there is no combinational path from
  // m_ready_i to s_ready_o. The skid register absorbs the one beat that can
  // arrive in the cycle the output stalls.
  assign s_ready_o = ~skid_valid_reg;
  assign accept    = s_valid_i & ~skid_valid_reg;
  assign out_xfer  = out_valid_reg & m_ready_i;
  // The output register can take a new beat when empty or draining this cycle.
  assign out_free  = ~out_valid_reg | m_ready_i;

  // ---------------------------------------------------------------------------
  // Packet FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= IDLE;
      mode_reg         <= SWAP_PASS;
      mode_ignored_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      mode_reg         <= mode_next;
      mode_ignored_reg <= mode_ignored_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Packet FSM: next state and effective mode. The first beat of a packet is
  // swapped with the mode presented alongside it, not the previously latched
  // one, so eff_mode bypasses the latch while IDLE.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next        = state_reg;
    mode_next         = mode_reg;
    mode_ignored_next = mode_ignored_reg;
    eff_mode          = mode_reg;
    case (state_reg)
      IDLE: begin
        eff_mode = mode_in;
        if (accept) begin
          mode_next = mode_in;
          if (!s_last_i) begin
            state_next = IN_PKT;
          end
        end
      end
      IN_PKT: begin
        eff_mode = mode_reg;
        if (accept) begin
          if (mode_in != mode_reg) begin
            mode_ignored_next = 1'b1;
          end
          if (s_last_i) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane permutation ahead of the registers
  // ---------------------------------------------------------------------------
  lane_permute #(
    .BYTE_SIZE   (BYTE_SIZE),
    .INPUT_BYTES (INPUT_BYTES)
  ) u_permute (
    .data_i (s_data_i),
    .keep_i (s_keep_i),
    .mode_i (eff_mode),
    .data_o (sw_data),
    .keep_o (sw_keep)
  );

  // ---------------------------------------------------------------------------
  // Output / skid pipeline.
  // While the skid register is full, no beat is accepted, so when the output
  // frees up the skid beat always has priority and accept is necessarily 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_keep_reg   <= '0;
      out_last_reg   <= 1'b0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
      skid_keep_reg  <= '0;
      skid_last_reg  <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid_reg) begin
          out_valid_reg  <= 1'b1;
          out_data_reg   <= skid_data_reg;
          out_keep_reg   <= skid_keep_reg;
          out_last_reg   <= skid_last_reg;
          skid_valid_reg <= 1'b0;
        end else if (accept) begin
          out_valid_reg <= 1'b1;
          out_data_reg  <= sw_data;
          out_keep_reg  <= sw_keep;
          out_last_reg  <= s_last_i;
        end else begin
          // Data fields are left as they are; only valid drops.
          out_valid_reg <= 1'b0;
        end
      end else if (accept) begin
        // Output is stalled and holding a beat: park the new one.
        skid_valid_reg <= 1'b1;
        skid_data_reg  <= sw_data;
        skid_keep_reg  <= sw_keep;
        skid_last_reg  <= s_last_i;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status counters, advanced on output transfers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt_reg  <= '0;
      beat_cnt_reg <= '0;
    end else if (out_xfer) begin
      if (out_last_reg) begin
        beat_cnt_reg <= '0;
        pkt_cnt_reg  <= pkt_cnt_reg + CNT_W'(1);
      end else begin
        beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign m_valid_o      = out_valid_reg;
  assign m_data_o       = out_data_reg;
  assign m_keep_o       = out_keep_reg;
  assign m_last_o       = out_last_reg;
  assign pkt_cnt_o      = pkt_cnt_reg;
  assign beat_cnt_o     = beat_cnt_reg;
  assign mode_ignored_o = mode_ignored_reg;

endmodule : endian_swap_stream

// File: tb/tb_endian_swap_stream.sv
// -----------------------------------------------------------------------------
// tb_endian_swap_stream
//
// Directed and randomized stimulus against a queue-based reference model.
// The model keeps the list of beats accepted but not yet delivered, so
// occupancy, ordering, ready/valid and counters all follow from it.
// The DUT is built with CNT_W=4 so counter wraparound is reachable.
// -----------------------------------------------------------------------------
module tb_endian_swap_stream;

  localparam int BS = 8;
  localparam int NB = 4;
  localparam int DW = BS * NB;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    mode;
  logic [DW-1:0] s_data;
  logic [NB-1:0] s_keep;
  logic          s_last;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] m_data;
  logic [NB-1:0] m_keep;
  logic          m_last;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] pkt_cnt;
  logic [CW-1:0] beat_cnt;
  logic          mode_ignored;

  always #5 clk = ~clk;

  endian_swap_stream #(
    .BYTE_SIZE   (BS),
    .INPUT_BYTES (NB),
    .CNT_W       (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .mode_i         (mode),
    .s_data_i       (s_data),
    .s_keep_i       (s_keep),
    .s_last_i       (s_last),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .m_data_o       (m_data),
    .m_keep_o       (m_keep),
    .m_last_o       (m_last),
    .m_valid_o      (m_valid),
    .m_ready_i      (m_ready),
    .pkt_cnt_o      (pkt_cnt),
    .beat_cnt_o     (beat_cnt),
    .mode_ignored_o (mode_ignored)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [NB-1:0] k;
    logic          l;
  } beat_t;

  int checks = 0;
  int errors = 0;

  // Reference model state
  beat_t         exp_q[$];
  logic [CW-1:0] m_pkt;
  logic [CW-1:0] m_beat;
  bit            m_in_pkt;
  logic [1:0]    m_mode;
  bit            m_ign;

  bit            last_acc;
  logic [DW-1:0] got_data;
  logic [NB-1:0] got_keep;
  logic          got_last;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference swap, expressed in terms of bytes and 16-bit halfwords.
  function automatic beat_t ref_beat(logic [DW-1:0] d, logic [NB-1:0] k,
                                     logic l, logic [1:0] md);
    beat_t r;
    r.l = l;
    r.d = d;
    r.k = k;
    case (md)
      2'd1: begin  // whole beat read back to front
        for (int i = 0; i < NB; i++) begin
          r.d[8*i +: 8] = d[8*(NB-1-i) +: 8];
          r.k[i]        = k[NB-1-i];
        end
      end
      2'd2: begin  // each halfword byte-swapped in place
        for (int h = 0; h < NB/2; h++) begin
          r.d[16*h +: 8]     = d[16*h+8 +: 8];
          r.d[16*h+8 +: 8]   = d[16*h +: 8];
          r.k[2*h]           = k[2*h+1];
          r.k[2*h+1]         = k[2*h];
        end
      end
      2'd3: begin  // halfwords reversed, bytes within each kept
        for (int h = 0; h < NB/2; h++) begin
          r.d[16*h +: 16]  = d[16*(NB/2-1-h) +: 16];
          r.k[2*h +: 2]    = k[2*(NB/2-1-h) +: 2];
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // One clock cycle: compare handshake state before the edge, advance the
  // model, then compare registered status after the edge.
  task automatic step();
    bit            acc;
    bit            xfer;
    bit            stalled;
    logic [DW-1:0] hd;
    logic [NB-1:0] hk;
    logic          hl;
    logic [1:0]    md;
    chk("s_ready", s_ready, exp_q.size() < 2);
    chk("m_valid", m_valid, exp_q.size() > 0);
    acc     = s_valid && s_ready;
    xfer    = m_valid && m_ready;
    stalled = m_valid && !m_ready;
    hd = m_data;
    hk = m_keep;
    hl = m_last;
    if (xfer && exp_q.size() > 0) begin
      chk("m_data", m_data, exp_q[0].d);
      chk("m_keep", m_keep, exp_q[0].k);
      chk("m_last", m_last, exp_q[0].l);
      got_data = m_data;
      got_keep = m_keep;
      got_last = m_last;
      if (exp_q[0].l) begin
        m_beat = '0;
        m_pkt  = m_pkt + 1'b1;
      end else begin
        m_beat = m_beat + 1'b1;
      end
      void'(exp_q.pop_front());
    end
    if (acc) begin
      if (!m_in_pkt) begin
        md       = mode;
        m_mode   = mode;
        m_in_pkt = !s_last;
      end else begin
        md = m_mode;
        if (mode != m_mode) m_ign = 1'b1;
        if (s_last) m_in_pkt = 1'b0;
      end
      exp_q.push_back(ref_beat(s_data, s_keep, s_last, md));
    end
    last_acc = acc;
    @(posedge clk);
    #1;
    chk("pkt_cnt", pkt_cnt, m_pkt);
    chk("beat_cnt", beat_cnt, m_beat);
    chk("mode_ignored", mode_ignored, m_ign);
    if (stalled) begin
      chk("stall_valid", m_valid, 1'b1);
      chk("stall_data", m_data, hd);
      chk("stall_keep", m_keep, hk);
      chk("stall_last", m_last, hl);
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    m_pkt    = '0;
    m_beat   = '0;
    m_in_pkt = 1'b0;
    m_mode   = 2'd0;
    m_ign    = 1'b0;
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_mode_ignored", mode_ignored, 1'b0);
  endtask

  // Present one beat until it is accepted, bounded.
  task automatic send(logic [DW-1:0] d, logic [NB-1:0] k, logic l, logic [1:0] md);
    s_data   = d;
    s_keep   = k;
    s_last   = l;
    mode     = md;
    s_valid  = 1'b1;
    last_acc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc) break;
    end
    checks++;
    assert (last_acc)
    else begin
      errors++;
      $error("FAIL send_timeout observed=not_accepted expected=accepted");
    end
    s_valid = 1'b0;
  endtask

  initial begin
    int idx;
    bit saw_low;
    rst     = 1'b1;
    mode    = 2'd0;
    s_data  = '0;
    s_keep  = '0;
    s_last  = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    m_pkt   = '0;
    m_beat  = '0;
    m_in_pkt = 1'b0;
    m_mode  = 2'd0;
    m_ign   = 1'b0;
    got_data = '0;
    got_keep = '0;
    got_last = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Single-beat FULL swap
    send(32'h11223344, 4'hF, 1'b1, 2'd1);
    chk("t1_valid_next", m_valid, 1'b1);
    chk("t1_data_next", m_data, 32'h44332211);
    step();
    chk("t1_data", got_data, 32'h44332211);
    chk("t1_last", got_last, 1'b1);
    chk("t1_pkt_cnt", pkt_cnt, 1);
    chk("t1_beat_cnt", beat_cnt, 0);

    // HALF16 two-beat packet, WORD16 single beat, keep permutation
    send(32'hAABBCCDD, 4'hF, 1'b0, 2'd2);
    send(32'h01020304, 4'hF, 1'b1, 2'd2);
    chk("half16_b0", got_data, 32'hBBAADDCC);
    step();
    chk("half16_b1", got_data, 32'h02010403);
    send(32'hAABBCCDD, 4'hF, 1'b1, 2'd3);
    step();
    chk("word16", got_data, 32'hCCDDAABB);
    send(32'h12345678, 4'b0011, 1'b1, 2'd1);
    step();
    chk("keep_full", got_keep, 4'b1100);

    // Mode change mid-packet is ignored and flagged
    send(32'h01020304, 4'hF, 1'b0, 2'd1);
    chk("ign_before", mode_ignored, 1'b0);
    send(32'h05060708, 4'hF, 1'b0, 2'd0);
    chk("ign_after_b2", mode_ignored, 1'b1);
    send(32'h0A0B0C0D, 4'hF, 1'b1, 2'd0);
    step();
    chk("ign_b3_reversed", got_data, 32'h0D0C0B0A);
    send(32'h0A0B0C0D, 4'hF, 1'b1, 2'd0);
    step();
    chk("next_pkt_pass", got_data, 32'h0A0B0C0D);

    // 5-beat stream with a 3-cycle downstream stall
    idx = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 40 && (idx < 5 || exp_q.size() > 0); c++) begin
      m_ready = !(c >= 1 && c <= 3);
      s_valid = (idx < 5);
      s_data  = 32'h10000000 + idx;
      s_keep  = 4'hF;
      s_last  = (idx == 4);
      mode    = 2'd3;
      if (!s_ready) saw_low = 1'b1;
      step();
      if (last_acc) idx++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("stall_ready_dropped", saw_low, 1'b1);
    chk("stall_all_sent", idx, 5);
    chk("stall_all_drained", exp_q.size(), 0);

    // Reset with the skid register full mid-packet
    m_ready = 1'b0;
    send(32'hA1A2A3A4, 4'hF, 1'b0, 2'd2);
    send(32'hB1B2B3B4, 4'hF, 1'b0, 2'd2);
    chk("pre_rst_skid_full", s_ready, 1'b0);
    do_reset();
    m_ready = 1'b1;
    send(32'h11223344, 4'hF, 1'b1, 2'd1);
    step();
    chk("post_rst_mode1", got_data, 32'h44332211);

    // Counter wraparound with CNT_W=4
    do_reset();
    for (int p = 0; p < 17; p++) begin
      send($urandom, 4'(  $urandom), 1'b1, 2'($urandom));
    end
    step();
    step();
    chk("pkt_cnt_wrap", pkt_cnt, 1);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = $urandom;
      s_keep  = 4'($urandom);
      s_last  = ($urandom_range(0, 3) == 0);
      mode    = 2'($urandom);
      m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) step();
    chk("final_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_endian_swap_stream
